controle_tampador: RTL and testbench
====================================

// Module: controle_tampador
// PURPOSE
//  Capping-station sequencer; the producer side of the cork-counter interface.
//  Detects bottles on the conveyor and stops the belt.
//  Issues clean Tampar (cap) pulses to the cork counter, gated by its TemR (corks available) flag.
//  Raises a refill request and an alarm when starved, detects jammed bottles, and keeps a capped-bottle count.
// PARAMETERS
//  CAP_CYCLES  4    cycles Tampar is held high per cap (>=1)
//  JAM_CYCLES  200  max cycles garrafa may stay high in RELEASE before jam (>=1)
//  CNT_W       8    width of capped-bottle counter
// PORTS
//  CLKplaca     in   1      system clock, all logic on rising edge
//  ini          in   1      synchronous active-high reset
//  garrafa      in   1      bottle-present sensor, asynchronous level
//  TemR         in   1      cork counter non-zero flag
//  Tampar       out  1      cap command pulse to cork counter
//  esteira      out  1      conveyor motor enable
//  pedir_rolha  out  1      refill request (drives the counter's adicionar path)
//  alarme       out  1      starve or jam indication
//  garrafas     out  CNT_W  bottles capped since reset
// BEHAVIOUR
//  - Reset is synchronous, active-high, and has priority everywhere. When ini=1 at a clock edge:
//    state=IDLE, sync flops=0, all counters=0, Tampar=0, pedir_rolha=0, alarme=0, garrafas=0, esteira=1.
//    An ini pulse during any state, including mid-CAP, aborts that state and count is not incremented.
//  - garrafa passes through a 2-FF synchronizer to give g_s; g_prev = g_s delayed one cycle.
//    rise = g_s & ~g_prev.
//  - All outputs are registered Moore decodes of the state.
//  - IDLE:    esteira=1. On rise -> CHECK.
//             A bottle already present at reset is ignored until garrafa goes low, then high.
//  - CHECK:   one cycle, esteira=0. TemR=1 -> CAP; TemR=0 -> STARVE.
//  - STARVE:  esteira=0, pedir_rolha=1, alarme=1. When TemR=1 -> CAP.
//             If garrafa drops while in STARVE, stay in STARVE; the bottle still needs a cap.
//  - CAP:     Tampar=1, esteira=0, for exactly CAP_CYCLES cycles.
//             TemR changes during CAP are ignored.
//             On exit -> RELEASE, and garrafas += 1, saturating at 2^CNT_W-1 (no wrap).
//  - RELEASE: esteira=1. When g_s=0 -> IDLE.
//             Cycle counter: if g_s is still high after JAM_CYCLES cycles -> JAM.
//  - JAM:     esteira=0, alarme=1. Sticky until ini.
//  - Latency: rise in cycle n gives CHECK in n+1, and Tampar high in cycles n+2 .. n+1+CAP_CYCLES when TemR=1.
//  - Exactly one Tampar pulse per bottle.
//    Tampar is never asserted while the state is not CAP, so the counter's debouncer always sees a clean pulse of fixed width.
//  - Starvation is non-sticky: once a cap completes, pedir_rolha and alarme return to 0.
// TESTING
//  1. Reset with ini=1 while garrafa=1, then release ini.
//     -> esteira=1, garrafas=0. No Tampar until garrafa goes 0 then 1.
//  2. TemR=1, one bottle of 30 cycles. -> Tampar high exactly 4 cycles, starting 2 cycles after rise.
//     garrafas=1. esteira 0 during CHECK and CAP, back to 1 in RELEASE, IDLE after garrafa=0.
//  3. TemR=0 at arrival. -> STARVE: pedir_rolha=1, alarme=1, esteira=0.
//     Raise TemR 50 cycles later -> one Tampar pulse of 4 cycles, then pedir_rolha=0, alarme=0.
//  4. garrafa held high 250 cycles after cap (JAM_CYCLES=200). -> JAM: alarme=1, esteira=0.
//     Stays in JAM after garrafa drops, until ini.
//  5. ini asserted in the 2nd cycle of CAP. -> Tampar=0 next cycle, garrafas stays at prior value, state IDLE.
//  6. CNT_W=3 with 9 bottles. -> garrafas saturates at 7.
//     Also drop TemR mid-CAP -> pulse still 4 cycles.

Source files
------------

// File: rtl/controle_tampador.sv
`default_nettype none
// ============================================================================
// controle_tampador: capping-station sequencer feeding the cork counter.
// Rev 1.0
// ============================================================================
module controle_tampador #(
    parameter int CAP_CYCLES = 4,
    parameter int JAM_CYCLES = 200,
    parameter int CNT_W      = 8
) (
    input  logic             CLKplaca,
    input  logic             ini,
    input  logic             garrafa,
    input  logic             TemR,
    output logic             Tampar,
    output logic             esteira,
    output logic             pedir_rolha,
    output logic             alarme,
    output logic [CNT_W-1:0] garrafas
);

    localparam int TMR_MAX = (CAP_CYCLES > JAM_CYCLES) ? CAP_CYCLES : JAM_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] CAP_LAST = TMR_W'(CAP_CYCLES - 1);
    localparam logic [TMR_W-1:0] JAM_LAST = TMR_W'(JAM_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_STARVE  = 3'd2;
    localparam logic [2:0] S_CAP     = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_JAM     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, g_s_q, g_prev_q;
    logic [1:0]       fill_q, fill_d;
    logic             armed_q, armed_d;
    logic             tampar_q, tampar_d;
    logic             esteira_q, esteira_d;
    logic             pedir_q, pedir_d;
    logic             alarme_q, alarme_d;
    logic             rise;

    // A bottle sitting on the sensor at reset must not trigger a cap: rises are
    // only honoured once the filled synchronizer has shown garrafa low.
    assign rise = g_s_q & ~g_prev_q & armed_q;

    always_ff @(posedge CLKplaca) begin
        if (ini) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            g_s_q     <= 1'b0;
            g_prev_q  <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
            tampar_q  <= 1'b0;
            esteira_q <= 1'b1;
            pedir_q   <= 1'b0;
            alarme_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            sync1_q   <= garrafa;
            g_s_q     <= sync1_q;
            g_prev_q  <= g_s_q;
            fill_q    <= fill_d;
            armed_q   <= armed_d;
            tampar_q  <= tampar_d;
            esteira_q <= esteira_d;
            pedir_q   <= pedir_d;
            alarme_q  <= alarme_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        cnt_d   = cnt_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~g_s_q);
        case (state_q)
            S_IDLE:    if (rise) state_d = S_CHECK;
            S_CHECK:   state_d = TemR ? S_CAP : S_STARVE;
            S_STARVE:  if (TemR) state_d = S_CAP;
            S_CAP: begin
                if (tmr_q == CAP_LAST) begin
                    state_d = S_RELEASE;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!g_s_q)                 state_d = S_IDLE;
                else if (tmr_q == JAM_LAST) state_d = S_JAM;
                else                        tmr_d   = tmr_q + 1'b1;
            end
            S_JAM:     state_d = S_JAM;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with state_q; Tampar is therefore high exactly while the state is CAP.
    always_comb begin
        tampar_d  = (state_d == S_CAP);
        esteira_d = (state_d == S_IDLE) || (state_d == S_RELEASE);
        pedir_d   = (state_d == S_STARVE);
        alarme_d  = (state_d == S_STARVE) || (state_d == S_JAM);
    end

    assign Tampar      = tampar_q;
    assign esteira     = esteira_q;
    assign pedir_rolha = pedir_q;
    assign alarme      = alarme_q;
    assign garrafas    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_tampador.sv
`default_nettype none
// ============================================================================
// tb_controle_tampador: self-checking bench with a behavioural capping model.
// Rev 1.0
// ============================================================================
module tb_controle_tampador;

    localparam int CAP = 4;
    localparam int JAM = 200;
    localparam int CW  = 3;

    localparam int M_WAIT     = 0;
    localparam int M_DECIDE   = 1;
    localparam int M_HUNGRY   = 2;
    localparam int M_CAPPING  = 3;
    localparam int M_LEAVE    = 4;
    localparam int M_STUCK    = 5;

    logic          CLKplaca = 1'b0;
    logic          ini      = 1'b1;
    logic          garrafa  = 1'b0;
    logic          TemR     = 1'b0;
    logic          Tampar, esteira, pedir_rolha, alarme;
    logic [CW-1:0] garrafas;

    controle_tampador #(
        .CAP_CYCLES(CAP), .JAM_CYCLES(JAM), .CNT_W(CW)
    ) dut (
        .CLKplaca   (CLKplaca),
        .ini        (ini),
        .garrafa    (garrafa),
        .TemR       (TemR),
        .Tampar     (Tampar),
        .esteira    (esteira),
        .pedir_rolha(pedir_rolha),
        .alarme     (alarme),
        .garrafas   (garrafas)
    );

    always #5 CLKplaca = ~CLKplaca;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int m_s1 = 0, m_gs = 0, m_gprev = 0, m_fill = 0, m_armed = 0;
    int m_mode = M_WAIT, m_left = 0, m_hold = 0, m_count = 0;

    // pulse observation
    int run_len = 0, last_w = 0, pulses = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit rise;
        if (ini) begin
            m_s1 = 0; m_gs = 0; m_gprev = 0; m_fill = 0; m_armed = 0;
            m_mode = M_WAIT; m_left = 0; m_hold = 0; m_count = 0;
        end else begin
            rise = (m_gs != 0) && (m_gprev == 0) && (m_armed != 0);
            case (m_mode)
                M_WAIT:    if (rise) m_mode = M_DECIDE;
                M_DECIDE:  if (TemR) begin m_mode = M_CAPPING; m_left = CAP; end
                           else m_mode = M_HUNGRY;
                M_HUNGRY:  if (TemR) begin m_mode = M_CAPPING; m_left = CAP; end
                M_CAPPING: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_LEAVE;
                        m_hold = 0;
                        if (m_count < (1 << CW) - 1) m_count++;
                    end
                end
                M_LEAVE: begin
                    if (m_gs == 0) m_mode = M_WAIT;
                    else begin
                        m_hold++;
                        if (m_hold == JAM) m_mode = M_STUCK;
                    end
                end
                default: ;
            endcase
            if (m_fill >= 2 && m_gs == 0) m_armed = 1;
            if (m_fill < 2) m_fill++;
            m_gprev = m_gs;
            m_gs    = m_s1;
            m_s1    = int'(garrafa);
        end
    endtask

    task automatic tick();
        @(posedge CLKplaca);
        model_step();
        #1;
        check_eq("Tampar",      int'(Tampar),      int'(m_mode == M_CAPPING));
        check_eq("esteira",     int'(esteira),     int'(m_mode == M_WAIT || m_mode == M_LEAVE));
        check_eq("pedir_rolha", int'(pedir_rolha), int'(m_mode == M_HUNGRY));
        check_eq("alarme",      int'(alarme),      int'(m_mode == M_HUNGRY || m_mode == M_STUCK));
        check_eq("garrafas",    int'(garrafas),    m_count);
        if (Tampar) run_len++;
        else if (run_len > 0) begin
            last_w = run_len;
            pulses++;
            run_len = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        ini = 1'b1;
        run(2);
        ini = 1'b0;
        run(3);
    endtask

    int p0, k;

    initial begin
        // 1: bottle present through reset is ignored until it leaves and returns
        ini = 1'b1; garrafa = 1'b1; TemR = 1'b1;
        run(3);
        check_eq("t1_reset_esteira", int'(esteira), 1);
        check_eq("t1_reset_count",   int'(garrafas), 0);
        ini = 1'b0;
        p0 = pulses;
        run(20);
        check_eq("t1_no_cap", pulses, p0);
        garrafa = 1'b0; run(5);
        garrafa = 1'b1; run(30);
        check_eq("t1_cap_after_low", pulses, p0 + 1);
        garrafa = 1'b0; run(10);

        // 2: one bottle with corks available
        do_reset();
        TemR = 1'b1; garrafa = 1'b1; p0 = pulses; k = 0;
        while (!Tampar && k < 20) begin tick(); k++; end
        check_eq("t2_latency", k, 4);
        run(30 - k);
        check_eq("t2_width",   last_w, CAP);
        check_eq("t2_pulses",  pulses, p0 + 1);
        check_eq("t2_count",   int'(garrafas), 1);
        check_eq("t2_release", int'(esteira), 1);
        garrafa = 1'b0; run(4);
        check_eq("t2_idle", int'(esteira), 1);

        // 3: starved, then refilled
        do_reset();
        TemR = 1'b0; garrafa = 1'b1; run(10);
        check_eq("t3_pedir",  int'(pedir_rolha), 1);
        check_eq("t3_alarme", int'(alarme), 1);
        check_eq("t3_belt",   int'(esteira), 0);
        garrafa = 1'b0; run(40);
        check_eq("t3_stay", int'(pedir_rolha), 1);
        p0 = pulses;
        TemR = 1'b1; run(10);
        check_eq("t3_width",  last_w, CAP);
        check_eq("t3_pulses", pulses, p0 + 1);
        check_eq("t3_pedir0", int'(pedir_rolha), 0);
        check_eq("t3_alarm0", int'(alarme), 0);

        // 4: jammed bottle
        do_reset();
        TemR = 1'b1; garrafa = 1'b1; run(260);
        check_eq("t4_alarme", int'(alarme), 1);
        check_eq("t4_belt",   int'(esteira), 0);
        garrafa = 1'b0; run(20);
        check_eq("t4_sticky", int'(alarme), 1);
        do_reset();
        check_eq("t4_cleared", int'(alarme), 0);

        // 5: reset in the second cycle of CAP
        TemR = 1'b1; garrafa = 1'b1; k = 0;
        while (!Tampar && k < 20) begin tick(); k++; end
        check_eq("t5_reached_cap", int'(Tampar), 1);
        tick();
        ini = 1'b1; tick(); ini = 1'b0;
        check_eq("t5_tampar", int'(Tampar), 0);
        check_eq("t5_count",  int'(garrafas), 0);
        check_eq("t5_idle",   int'(esteira), 1);
        garrafa = 1'b0; run(5);
        run_len = 0;

        // 6: counter saturation, TemR wobbling during CAP
        do_reset();
        for (int b = 0; b < 9; b++) begin
            TemR = 1'b1; garrafa = 1'b1; run(5);
            TemR = 1'($urandom_range(0, 1)); run(10);
            TemR = 1'b1; garrafa = 1'b0; run(6);
            check_eq("t6_width", last_w, CAP);
        end
        check_eq("t6_saturate", int'(garrafas), 7);

        // random traffic against the model
        do_reset();
        for (int r = 0; r < 60; r++) begin
            garrafa = 1'($urandom_range(0, 1));
            TemR    = ($urandom_range(0, 3) != 0);
            ini     = ($urandom_range(0, 29) == 0);
            tick();
            ini = 1'b0;
            run($urandom_range(1, 25));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
